// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - APB initiator turning valid/ready register commands into APB transfers
//
// Ports:
//   pclk, preset                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_write/cmd_addr/cmd_wdata       command direction, register address, write data
//   rsp_valid                          one-cycle response pulse
//   rsp_rdata/rsp_err/rsp_timeout      response payload, held until the next response
//   busy                               transfer in progress
//   paddr/pwrite/pwdata/psel/penable   APB request outputs
//   prdata/pready/pslverr              APB completion inputs
module apb_master_bridge #(
   parameter int ADDR_W  = 3,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              busy,
   output logic [ADDR_W-1:0] paddr,
   output logic              pwrite,
   output logic [DATA_W-1:0] pwdata,
   output logic              psel,
   output logic              penable,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   // Count value on the last allowed ACCESS cycle; no pready here means abort.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  wait_cnt;
   logic              accept;
   logic              done;
   logic              abort;

   logic              psel_nxt;
   logic              penable_nxt;
   logic              rsp_valid_nxt;
   logic [DATA_W-1:0] rsp_rdata_nxt;
   logic              rsp_err_nxt;
   logic              rsp_timeout_nxt;

   assign cmd_ready = (state == S_IDLE) & ~preset;
   assign busy      = (state != S_IDLE);
   assign accept    = cmd_valid & cmd_ready;
   // Completion takes priority over abort when pready arrives on the last cycle.
   assign done      = (state == S_ACCESS) & pready;
   assign abort     = (state == S_ACCESS) & ~pready & (wait_cnt == CNT_LAST);

   // State, registered outputs and the captured command.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state       <= S_IDLE;
         wait_cnt    <= '0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         psel        <= psel_nxt;
         penable     <= penable_nxt;
         rsp_valid   <= rsp_valid_nxt;
         rsp_rdata   <= rsp_rdata_nxt;
         rsp_err     <= rsp_err_nxt;
         rsp_timeout <= rsp_timeout_nxt;
         if (accept) begin
            paddr    <= cmd_addr;
            pwrite   <= cmd_write;
            pwdata   <= cmd_wdata;
            wait_cnt <= '0;
         end else if ((state == S_ACCESS) && !pready) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept) state_nxt = S_SETUP;
         S_SETUP:  state_nxt = S_ACCESS;
         S_ACCESS: if (done || abort) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Output logic: values loaded into the output registers at the next edge.
   always_comb begin
      psel_nxt        = (state_nxt != S_IDLE);
      penable_nxt     = (state_nxt == S_ACCESS);
      rsp_valid_nxt   = done | abort;
      rsp_rdata_nxt   = rsp_rdata;
      rsp_err_nxt     = rsp_err;
      rsp_timeout_nxt = rsp_timeout;
      if (done) begin
         rsp_rdata_nxt   = pwrite ? '0 : prdata;
         rsp_err_nxt     = pslverr;
         rsp_timeout_nxt = 1'b0;
      end else if (abort) begin
         rsp_rdata_nxt   = '0;
         rsp_err_nxt     = 1'b1;
         rsp_timeout_nxt = 1'b1;
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - scoreboard bench for apb_master_bridge
module tb_apb_master_bridge;
   localparam int AW = 3;
   localparam int DW = 8;
   localparam int TO = 16;

   logic          pclk = 1'b0;
   logic          preset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;
   logic          busy;
   logic [AW-1:0] paddr;
   logic          pwrite;
   logic [DW-1:0] pwdata;
   logic          psel;
   logic          penable;
   logic [DW-1:0] prdata;
   logic          pready;
   logic          pslverr;

   apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .pclk(pclk), .preset(preset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_timeout(rsp_timeout), .busy(busy),
      .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      bit          wr;
      bit [AW-1:0] addr;
      bit [DW-1:0] wdata;
      int          wt;      // cycles pready stays low in ACCESS
      bit          slverr;
      bit [DW-1:0] rdata;
   } tx_t;

   typedef struct {
      bit [DW-1:0] rdata;
      bit          err;
      bit          to;
      int          cyc;
   } rsp_t;

   tx_t  txq[$];
   rsp_t expq[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   function automatic int access_cycles(tx_t t);
      return (t.wt >= TO) ? TO : t.wt + 1;
   endfunction

   function automatic rsp_t model(tx_t t, int acc_cyc);
      rsp_t r;
      r.to    = (t.wt >= TO);
      r.err   = r.to | t.slverr;
      r.rdata = (r.to || t.wr) ? '0 : t.rdata;
      r.cyc   = acc_cyc + 2 + access_cycles(t);
      return r;
   endfunction

   function automatic tx_t mk(bit wr, int addr, int wdata, int wt, bit slverr, int rdata);
      tx_t t;
      t.wr = wr; t.addr = AW'(addr); t.wdata = DW'(wdata);
      t.wt = wt; t.slverr = slverr; t.rdata = DW'(rdata);
      return t;
   endfunction

   function automatic tx_t rand_tx();
      int wt;
      wt = ($urandom_range(0, 3) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 4);
      return mk(1'($urandom), $urandom_range(0, 7), $urandom_range(0, 255), wt,
                1'($urandom), $urandom_range(0, 255));
   endfunction

   // Presents one command and returns at the negedge after it is accepted.
   task automatic issue(input tx_t t, input bit expect_rsp, output int acc_cyc);
      int n;
      n = 0;
      acc_cyc = -1;
      cmd_valid = 1'b1;
      cmd_write = t.wr;
      cmd_addr  = t.addr;
      cmd_wdata = t.wdata;
      txq.push_back(t);
      while (!cmd_ready && n < 300) begin
         @(negedge pclk);
         n++;
      end
      chk("cmd_accept", cmd_ready, 1'b1);
      if (cmd_ready) begin
         acc_cyc = cyc;
         if (expect_rsp) expq.push_back(model(t, cyc));
      end
      @(negedge pclk);
   endtask

   initial forever begin
      @(posedge pclk);
      cyc++;
   end

   // APB slave: checks the request phase, drives pready after the scheduled wait.
   initial begin
      tx_t cur;
      int  acc;
      bit  active;
      active = 1'b0;
      acc = 0;
      pready = 1'b0;
      pslverr = 1'b0;
      prdata = '0;
      forever begin
         @(negedge pclk);
         if (preset) begin
            active = 1'b0;
            pready = 1'b0;
         end else if (psel && !penable) begin
            if (txq.size() == 0) begin
               chk("setup_without_cmd", 1, 0);
            end else begin
               cur = txq.pop_front();
               active = 1'b1;
               acc = 0;
               chk("setup_paddr", paddr, cur.addr);
               chk("setup_pwrite", pwrite, cur.wr);
               if (cur.wr) chk("setup_pwdata", pwdata, cur.wdata);
               chk("setup_busy", busy, 1'b1);
               chk("setup_cmd_ready", cmd_ready, 1'b0);
            end
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
            prdata  = DW'($urandom);
         end else if (psel && penable) begin
            chk("access_active", active, 1'b1);
            chk("access_paddr_stable", paddr, cur.addr);
            chk("access_pwrite_stable", pwrite, cur.wr);
            if (acc == cur.wt) begin
               pready  = 1'b1;
               pslverr = cur.slverr;
               prdata  = cur.rdata;
            end else begin
               pready  = 1'b0;
               pslverr = 1'($urandom);
               prdata  = DW'($urandom);
            end
            acc++;
         end else begin
            if (penable) chk("penable_without_psel", 1, 0);
            if (active) begin
               chk("access_cycles", acc, access_cycles(cur));
               active = 1'b0;
            end
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
            prdata  = DW'($urandom);
         end
      end
   end

   // Response monitor: pops the scoreboard on every rsp_valid.
   initial begin
      rsp_t        e;
      bit          prev_rv;
      bit [DW-1:0] last_rdata;
      bit          last_err;
      bit          last_to;
      prev_rv = 1'b0;
      last_rdata = '0;
      last_err = 1'b0;
      last_to = 1'b0;
      forever begin
         @(negedge pclk);
         if (preset) begin
            prev_rv = 1'b0;
            last_rdata = '0;
            last_err = 1'b0;
            last_to = 1'b0;
         end else if (rsp_valid) begin
            if (prev_rv) chk("rsp_valid_one_cycle", 1, 0);
            if (expq.size() == 0) begin
               chk("unexpected_rsp", 1, 0);
            end else begin
               e = expq.pop_front();
               chk("rsp_rdata", rsp_rdata, e.rdata);
               chk("rsp_err", rsp_err, e.err);
               chk("rsp_timeout", rsp_timeout, e.to);
               chk("rsp_latency", cyc, e.cyc);
               last_rdata = e.rdata;
               last_err = e.err;
               last_to = e.to;
            end
            chk("rsp_cmd_ready", cmd_ready, 1'b1);
            prev_rv = 1'b1;
         end else begin
            chk("hold_rdata", rsp_rdata, last_rdata);
            chk("hold_err", rsp_err, last_err);
            chk("hold_timeout", rsp_timeout, last_to);
            prev_rv = 1'b0;
         end
      end
   end

   initial begin
      int a;
      int b;
      int n;
      preset = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr = '0;
      cmd_wdata = '0;
      repeat (3) @(negedge pclk);
      chk("rst_psel", psel, 1'b0);
      chk("rst_penable", penable, 1'b0);
      chk("rst_pwrite", pwrite, 1'b0);
      chk("rst_paddr", paddr, '0);
      chk("rst_pwdata", pwdata, '0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, '0);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_rsp_timeout", rsp_timeout, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cmd_ready_in_reset", cmd_ready, 1'b0);
      preset = 1'b0;
      @(negedge pclk);
      chk("cmd_ready_after_reset", cmd_ready, 1'b1);

      // Directed cases: write, read, slow read with slave error, completion on
      // the last allowed cycle, exact timeout, stuck pready.
      issue(mk(1, 0, 8'h5C, 0, 0, 8'h33), 1'b1, a); cmd_valid = 1'b0;
      repeat (3) @(negedge pclk);
      issue(mk(0, 5, 8'h00, 0, 0, 8'hA7), 1'b1, a); cmd_valid = 1'b0;
      repeat (3) @(negedge pclk);
      issue(mk(0, 2, 8'h00, 4, 1, 8'h99), 1'b1, a); cmd_valid = 1'b0;
      repeat (8) @(negedge pclk);
      issue(mk(0, 3, 8'h00, TO - 1, 0, 8'h6E), 1'b1, a); cmd_valid = 1'b0;
      repeat (TO + 3) @(negedge pclk);
      issue(mk(0, 4, 8'h00, TO, 0, 8'h11), 1'b1, a); cmd_valid = 1'b0;
      repeat (TO + 3) @(negedge pclk);
      issue(mk(1, 6, 8'hE1, 1000, 0, 8'h00), 1'b1, a); cmd_valid = 1'b0;
      repeat (TO + 3) @(negedge pclk);

      // Back-to-back with cmd_valid held: second accepted in the response cycle.
      issue(mk(1, 1, 8'h3C, 0, 0, 8'h00), 1'b1, a);
      issue(mk(0, 7, 8'h00, 0, 0, 8'h5A), 1'b1, b);
      cmd_valid = 1'b0;
      chk("b2b_interval", b - a, 3);
      repeat (3) @(negedge pclk);

      for (int i = 0; i < 60; i++) begin
         issue(rand_tx(), 1'b1, a);
         if ($urandom_range(0, 2) != 0) begin
            cmd_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge pclk);
         end
      end
      cmd_valid = 1'b0;

      n = 0;
      while ((expq.size() != 0 || txq.size() != 0) && n < 500) begin
         @(negedge pclk);
         n++;
      end
      chk("drain_expq", expq.size(), 0);
      chk("drain_txq", txq.size(), 0);

      // Reset in the middle of ACCESS: no response may follow.
      issue(mk(0, 5, 8'h00, 1000, 0, 8'h00), 1'b0, a);
      cmd_valid = 1'b0;
      repeat (2) @(negedge pclk);
      chk("mid_penable_before_reset", penable, 1'b1);
      preset = 1'b1;
      @(negedge pclk);
      chk("mid_rst_psel", psel, 1'b0);
      chk("mid_rst_penable", penable, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
      chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
      @(negedge pclk);
      preset = 1'b0;
      @(negedge pclk);
      chk("mid_rst_cmd_ready_after", cmd_ready, 1'b1);
      chk("mid_rst_busy_after", busy, 1'b0);
      repeat (TO + 4) @(negedge pclk);
      chk("mid_rst_no_psel", psel, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
